// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared constants, fetch state encoding and address checks
package rv32i_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FAULT = 2'd2
   } fetch_state_e;

   // Last byte of the word is computed one bit wider so a wrapping address never looks legal.
   function automatic logic addr_in_bounds(input logic [XLEN-1:0] addr,
                                           input logic [XLEN-1:0] mem_size);
      logic [XLEN:0] last_byte;
      logic [XLEN:0] limit;
      last_byte = {1'b0, addr} + {{(XLEN-1){1'b0}}, 2'd3};
      limit     = {1'b0, mem_size} - {{XLEN{1'b0}}, 1'b1};
      return last_byte <= limit;
   endfunction

   function automatic logic addr_legal(input logic [XLEN-1:0] addr,
                                       input logic [XLEN-1:0] mem_size);
      return (addr[1:0] == 2'b00) && addr_in_bounds(addr, mem_size);
   endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// rtl/fetch_next_pc.sv - next-PC priority mux, capture enable and fault decision
module fetch_next_pc
   import rv32i_pkg::*;
#(
   parameter int unsigned MEM_SIZE = 1024
) (
   input  fetch_state_e       state_i,
   input  logic [XLEN-1:0]    pc_i,
   input  logic               id_valid_i,
   input  logic               id_ready_i,
   input  logic               redirect_valid_i,
   input  logic [XLEN-1:0]    redirect_target_i,
   output fetch_state_e       state_d_o,
   output logic [XLEN-1:0]    pc_d_o,
   output logic               capture_o,
   output logic               flush_o,
   output logic               fault_o,
   output logic [XLEN-1:0]    fault_addr_o
);

   localparam logic [XLEN-1:0] MEM_SIZE_W = XLEN'(MEM_SIZE);

   always_comb begin
      state_d_o    = state_i;
      pc_d_o       = pc_i;
      capture_o    = 1'b0;
      flush_o      = 1'b0;
      fault_o      = 1'b0;
      fault_addr_o = pc_i;
      case (state_i)
         ST_BOOT: state_d_o = ST_RUN;
         ST_RUN: begin
            if (redirect_valid_i && !addr_legal(redirect_target_i, MEM_SIZE_W)) begin
               state_d_o    = ST_FAULT;
               fault_o      = 1'b1;
               fault_addr_o = redirect_target_i;
            end else if (redirect_valid_i) begin
               pc_d_o  = redirect_target_i;
               flush_o = 1'b1;
            end else if (!id_valid_i || id_ready_i) begin
               // Sequential PC stays aligned, so only the upper bound can fail here.
               if (!addr_in_bounds(pc_i, MEM_SIZE_W)) begin
                  state_d_o    = ST_FAULT;
                  fault_o      = 1'b1;
                  fault_addr_o = pc_i;
               end else begin
                  capture_o = 1'b1;
                  pc_d_o    = pc_i + XLEN'(4);
               end
            end
         end
         ST_FAULT: state_d_o = ST_FAULT;
         default:  state_d_o = ST_BOOT;
      endcase
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC, IF/ID register and sticky fetch fault
module instruction_fetch_unit
   import rv32i_pkg::XLEN;
   import rv32i_pkg::fetch_state_e;
   import rv32i_pkg::ST_BOOT;
#(
   parameter logic [31:0] RESET_PC  = 32'h00000000,
   parameter int unsigned MEM_SIZE  = 1024,
   parameter logic [31:0] NOP_INSTR = rv32i_pkg::NOP_INSTR
) (
   input  logic               Clk,
   input  logic               Reset,
   output logic [XLEN-1:0]    Imem_Addr,
   input  logic [XLEN-1:0]    Imem_Dout,
   input  logic               Redirect_Valid,
   input  logic [XLEN-1:0]    Redirect_Target,
   input  logic               Id_Ready,
   output logic               Id_Valid,
   output logic [XLEN-1:0]    Id_Instr,
   output logic [XLEN-1:0]    Id_PC,
   output logic [XLEN-1:0]    Id_PC_Plus4,
   output logic               Fault,
   output logic [XLEN-1:0]    Fault_Addr
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            id_valid_q;
   logic [XLEN-1:0] id_instr_q, id_pc_q, id_pc_plus4_q;
   logic            fault_q;
   logic [XLEN-1:0] fault_addr_q, fault_addr_d;
   logic            capture, flush, fault_set;

   fetch_next_pc #(
      .MEM_SIZE (MEM_SIZE)
   ) u_next_pc (
      .state_i           (state_q),
      .pc_i              (pc_q),
      .id_valid_i        (id_valid_q),
      .id_ready_i        (Id_Ready),
      .redirect_valid_i  (Redirect_Valid),
      .redirect_target_i (Redirect_Target),
      .state_d_o         (state_d),
      .pc_d_o            (pc_d),
      .capture_o         (capture),
      .flush_o           (flush),
      .fault_o           (fault_set),
      .fault_addr_o      (fault_addr_d)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q       <= ST_BOOT;
         pc_q          <= RESET_PC;
         id_valid_q    <= 1'b0;
         id_instr_q    <= NOP_INSTR;
         id_pc_q       <= '0;
         id_pc_plus4_q <= XLEN'(4);
         fault_q       <= 1'b0;
         fault_addr_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         if (fault_set) begin
            fault_q      <= 1'b1;
            fault_addr_q <= fault_addr_d;
            id_valid_q   <= 1'b0;
         end else if (flush) begin
            id_valid_q <= 1'b0;
            id_instr_q <= NOP_INSTR;
         end else if (capture) begin
            id_valid_q    <= 1'b1;
            id_instr_q    <= Imem_Dout;
            id_pc_q       <= pc_q;
            id_pc_plus4_q <= pc_q + XLEN'(4);
         end
      end
   end

   assign Imem_Addr   = pc_q;
   assign Id_Valid    = id_valid_q;
   assign Id_Instr    = id_instr_q;
   assign Id_PC       = id_pc_q;
   assign Id_PC_Plus4 = id_pc_plus4_q;
   assign Fault       = fault_q;
   assign Fault_Addr  = fault_addr_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

   localparam logic [31:0] NOP = 32'h00000013;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic [31:0] Imem_Addr, Imem_Dout;
   logic        Redirect_Valid = 1'b0;
   logic [31:0] Redirect_Target = 32'h0;
   logic        Id_Ready = 1'b0;
   logic        Id_Valid;
   logic [31:0] Id_Instr, Id_PC, Id_PC_Plus4;
   logic        Fault;
   logic [31:0] Fault_Addr;

   int checks = 0;
   int failures = 0;

   instruction_fetch_unit #(
      .RESET_PC  (32'h0),
      .MEM_SIZE  (1024),
      .NOP_INSTR (NOP)
   ) dut (
      .Clk             (Clk),
      .Reset           (Reset),
      .Imem_Addr       (Imem_Addr),
      .Imem_Dout       (Imem_Dout),
      .Redirect_Valid  (Redirect_Valid),
      .Redirect_Target (Redirect_Target),
      .Id_Ready        (Id_Ready),
      .Id_Valid        (Id_Valid),
      .Id_Instr        (Id_Instr),
      .Id_PC           (Id_PC),
      .Id_PC_Plus4     (Id_PC_Plus4),
      .Fault           (Fault),
      .Fault_Addr      (Fault_Addr)
   );

   always #5 Clk = ~Clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'd0)      return 32'h3e800093;
      else if (a == 32'd4) return 32'h00300113;
      else                 return 32'h0A000000 | a;
   endfunction

   always_comb Imem_Dout = mem_word(Imem_Addr);

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   typedef struct {
      logic        rst, rdy, rv;
      logic [31:0] rt;
      logic        e_valid;
      logic        e_chk_instr;
      logic [31:0] e_instr, e_pc, e_addr;
      logic        e_fault;
      logic [31:0] e_faddr;
   } vec_t;

   typedef struct {
      logic [31:0] pc, instr;
   } sb_t;

   vec_t vec[19];
   sb_t  sb_q[$];
   sb_t  sb_e;
   logic sb_en = 1'b0;

   // Every handshake seen by decode must match the next expected fetch.
   always @(negedge Clk) begin
      if (sb_en && !Reset && Id_Valid && Id_Ready) begin
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_underflow: got pc 0x%08h expected no transfer", Id_PC);
         end else begin
            sb_e = sb_q.pop_front();
            chk("sb_pc", Id_PC, sb_e.pc);
            chk("sb_instr", Id_Instr, sb_e.instr);
            chk("sb_plus4", Id_PC_Plus4, sb_e.pc + 32'd4);
         end
      end
   end

   task automatic reset_boot();
      Reset = 1'b1; Redirect_Valid = 1'b0; Id_Ready = 1'b1;
      tick();
      Reset = 1'b0;
      tick();
   endtask

   initial begin
      vec[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, NOP,          32'd0,  32'd0,  1'b0, 32'h0};
      vec[1]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, NOP,          32'd0,  32'd0,  1'b0, 32'h0};
      vec[2]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 32'h3e800093, 32'd0,  32'd4,  1'b0, 32'h0};
      vec[3]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 32'h00300113, 32'd4,  32'd8,  1'b0, 32'h0};
      vec[4]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 32'h0A000008, 32'd8,  32'd12, 1'b0, 32'h0};
      vec[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h0A000008, 32'd8,  32'd12, 1'b0, 32'h0};
      vec[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h0A000008, 32'd8,  32'd12, 1'b0, 32'h0};
      vec[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h0A000008, 32'd8,  32'd12, 1'b0, 32'h0};
      vec[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 32'h0A00000C, 32'd12, 32'd16, 1'b0, 32'h0};
      vec[9]  = '{1'b0, 1'b0, 1'b1, 32'd16, 1'b0, 1'b1, NOP,          32'd12, 32'd16, 1'b0, 32'h0};
      vec[10] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h0A000010, 32'd16, 32'd20, 1'b0, 32'h0};
      vec[11] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 32'h0A000014, 32'd20, 32'd24, 1'b0, 32'h0};
      vec[12] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 32'h0A000018, 32'd24, 32'd28, 1'b0, 32'h0};
      vec[13] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, NOP,          32'd0,  32'd0,  1'b0, 32'h0};
      vec[14] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, NOP,          32'd0,  32'd0,  1'b0, 32'h0};
      vec[15] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 32'h3e800093, 32'd0,  32'd4,  1'b0, 32'h0};
      vec[16] = '{1'b0, 1'b1, 1'b1, 32'h1A, 1'b0, 1'b0, 32'h0,        32'd0,  32'd4,  1'b1, 32'h1A};
      vec[17] = '{1'b0, 1'b1, 1'b1, 32'd32, 1'b0, 1'b0, 32'h0,        32'd0,  32'd4,  1'b1, 32'h1A};
      vec[18] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, NOP,          32'd0,  32'd0,  1'b0, 32'h0};

      for (int i = 0; i < 19; i++) begin
         Reset           = vec[i].rst;
         Id_Ready        = vec[i].rdy;
         Redirect_Valid  = vec[i].rv;
         Redirect_Target = vec[i].rt;
         tick();
         chk($sformatf("v%0d_valid", i), {31'b0, Id_Valid}, {31'b0, vec[i].e_valid});
         if (vec[i].e_chk_instr)
            chk($sformatf("v%0d_instr", i), Id_Instr, vec[i].e_instr);
         chk($sformatf("v%0d_pc", i), Id_PC, vec[i].e_pc);
         chk($sformatf("v%0d_plus4", i), Id_PC_Plus4, vec[i].e_pc + 32'd4);
         chk($sformatf("v%0d_addr", i), Imem_Addr, vec[i].e_addr);
         chk($sformatf("v%0d_fault", i), {31'b0, Fault}, {31'b0, vec[i].e_fault});
         chk($sformatf("v%0d_faddr", i), Fault_Addr, vec[i].e_faddr);
      end

      reset_boot();
      Redirect_Valid = 1'b1; Redirect_Target = 32'd1024;
      tick();
      Redirect_Valid = 1'b0;
      chk("redir_1024_fault", {31'b0, Fault}, 32'd1);
      chk("redir_1024_faddr", Fault_Addr, 32'd1024);
      chk("redir_1024_addr", Imem_Addr, 32'd0);

      reset_boot();
      Redirect_Valid = 1'b1; Redirect_Target = 32'hFFFFFFFC;
      tick();
      Redirect_Valid = 1'b0;
      chk("redir_wrap_fault", {31'b0, Fault}, 32'd1);
      chk("redir_wrap_faddr", Fault_Addr, 32'hFFFFFFFC);

      reset_boot();
      Redirect_Valid = 1'b1; Redirect_Target = 32'd1020;
      tick();
      Redirect_Valid = 1'b0;
      chk("redir_1020_fault", {31'b0, Fault}, 32'd0);
      chk("redir_1020_addr", Imem_Addr, 32'd1020);

      reset_boot();
      Redirect_Valid = 1'b1; Redirect_Target = 32'd1000;
      tick();
      Redirect_Valid = 1'b0;
      chk("redir_1000_addr", Imem_Addr, 32'd1000);
      for (int a = 1000; a <= 1020; a += 4)
         sb_q.push_back('{32'(a), mem_word(32'(a))});
      sb_en = 1'b1;
      for (int i = 0; i < 200 && !Fault; i++) begin
         Id_Ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      sb_en = 1'b0;
      chk("bound_fault", {31'b0, Fault}, 32'd1);
      chk("bound_faddr", Fault_Addr, 32'd1024);
      chk("bound_addr", Imem_Addr, 32'd1024);
      chk("bound_valid", {31'b0, Id_Valid}, 32'd0);
      chk("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Front-end stage directly upstream of the instruction memory.
- Owns the program counter and drives the memory's combinational read address.
- Captures the returned 32-bit word into an IF/ID pipeline register with a valid/ready handshake toward decode.
- Accepts branch/jump redirects from execute.
- Flags misaligned or out-of-range fetches as a sticky fault.

Parameters:
RESET_PC, 32'h00000000, byte address fetched first after reset
MEM_SIZE, 1024, instruction memory size in bytes; legal fetch requires PC+3 <= MEM_SIZE-1
NOP_INSTR, 32'h00000013, bubble encoding (addi x0,x0,0) loaded on reset/flush

Ports:
Clk  input  1  clock, rising edge
Reset  input  1  synchronous, active-high reset
Imem_Addr  output  32  byte read address to instruction memory (= PC, combinational)
Imem_Dout  input  32  instruction word returned combinationally for Imem_Addr
Redirect_Valid  input  1  execute requests PC change (taken branch/jal/jalr)
Redirect_Target  input  32  new PC when Redirect_Valid=1
Id_Ready  input  1  decode can accept the IF/ID register this cycle
Id_Valid  output  1  IF/ID register holds a valid instruction
Id_Instr  output  32  fetched instruction
Id_PC  output  32  address of Id_Instr
Id_PC_Plus4  output  32  Id_PC+4, for jal/jalr link
Fault  output  1  sticky fetch fault
Fault_Addr  output  32  offending address

Behaviour:
- Clock and reset: one clock (Clk); reset is synchronous and active-high (Reset), sampled on the Clk rising edge only.
- Reset values: PC=RESET_PC, state=BOOT, Id_Valid=0, Id_Instr=NOP_INSTR, Id_PC=0, Id_PC_Plus4=4, Fault=0, Fault_Addr=0. Reset overrides every other input in every state, including mid-stall and FAULT.
- Imem_Addr = PC at all times (FAULT included); no registered memory latency.
- States:
  - BOOT: one cycle, no capture, Id_Valid=0; goes to RUN.
  - RUN: normal fetch; evaluated per cycle in the priority order below.
  - FAULT: terminal until Reset.
- RUN priority, highest first:
  1. Redirect_Valid=1 with Redirect_Target[1:0]!=0, or Redirect_Target+3 > MEM_SIZE-1: go to FAULT; Fault<=1; Fault_Addr<=Redirect_Target; Id_Valid<=0.
  2. Redirect_Valid=1 (legal target): PC<=Redirect_Target; Id_Valid<=0; Id_Instr<=NOP_INSTR (flush). This applies even if Id_Ready=0, and the in-flight sequential fetch is discarded.
  3. Advance when Id_Valid=0 or Id_Ready=1:
     - If PC+3 > MEM_SIZE-1: go to FAULT; Fault_Addr<=PC; Id_Valid<=0.
     - Else: Id_Instr<=Imem_Dout; Id_PC<=PC; Id_PC_Plus4<=PC+4; Id_Valid<=1; PC<=PC+4.
  4. Otherwise (stall: Id_Valid=1, Id_Ready=0): hold all registers; outputs stable.
- Latency: the word at PC appears on Id_Instr on the edge that consumes it; first Id_Valid=1 is 2 cycles after Reset deasserts (BOOT plus one RUN cycle).
- Throughput: one instruction per cycle while Id_Ready=1.
- Arithmetic: PC+4 is 32-bit modulo 2^32; the bounds check catches wrap before any wrapped fetch occurs.
- FAULT: Id_Valid=0, PC frozen, Redirect_Valid ignored.
- Redirect_Target is only meaningful while Redirect_Valid=1; X-safe otherwise.

Decomposition:
- Shared package rv32i_pkg:
  - NOP_INSTR constant
  - fetch state encoding (BOOT=2'd0, RUN=2'd1, FAULT=2'd2)
  - XLEN=32
  - a legal-address check function (alignment + bound)
- One natural sub-module: fetch_next_pc, the combinational next-PC/priority mux that produces next PC, capture enable and fault decision. The state register and IF/ID register stay in the top.

Test Plan:
- Reset, then Id_Ready=1, memory holds 0x3e800093@0, 0x00300113@4 -> Id_Valid rises 2 cycles after reset release with Id_Instr=0x3e800093, Id_PC=0, Id_PC_Plus4=4; next cycle Id_Instr=0x00300113, Id_PC=4.
- Id_Ready=0 for 3 cycles while Id_Valid=1 at Id_PC=8 -> Id_Instr/Id_PC unchanged for all 3 cycles, Imem_Addr stays 12; on Ready=1, PC 12 is captured next.
- Redirect_Valid=1, Redirect_Target=16 with Id_Ready=0 and Id_Valid=1 -> next cycle Id_Valid=0, Id_Instr=0x00000013, Imem_Addr=16; following cycle Id_PC=16.
- Redirect_Target=0x0000001A -> Fault=1, Fault_Addr=0x1A, Id_Valid=0; further redirects ignored; Reset clears Fault and PC returns to 0.
- Sequential fetch with MEM_SIZE=1024 reaching PC=1020 then 1024 -> 1020 is fetched normally; at PC=1024, Fault=1 and Fault_Addr=1024.
- Assert Reset for one cycle mid-stream (PC=24, Id_Valid=1) -> next cycle PC=0, Id_Valid=0, Id_Instr=0x00000013, state BOOT.
